// File: rtl/fpu_result_uart_tx.sv
// Serialises a captured 32-bit floating point result as four 8N1 UART bytes, MSB byte first.
// The word is copied into a private shift register so the source may change mid-frame.
module fpu_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] result,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [31:0]   shift_reg;

    logic       bit_end;
    logic [2:0] next_bit;
    logic [7:0] cur_byte;

    assign bit_end   = (baud == BAUD_LAST);
    assign next_bit  = bit_cnt + 3'd1;
    assign cur_byte  = shift_reg[31:24];
    assign dbg_state = state;

    // tx is registered, so each transition loads the line level of the bit being entered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            baud      <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    baud <= '0;
                    if (send) begin
                        shift_reg <= result;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_cnt == 2'd3) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Stop bit runs straight into the next start bit, no idle gap.
                            shift_reg <= {shift_reg[23:0], 8'h00};
                            byte_cnt  <= byte_cnt + 2'd1;
                            tx        <= 1'b0;
                            state     <= START;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx: UART decode against an expected byte queue,
// frame timing, mid-frame result change, ignored send, reset abort, back-to-back and fast baud.
module tb_fpu_result_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        send, send2;
    logic [31:0] result, result2;
    logic        tx, busy, done;
    logic        tx2, busy2, done2;
    logic [1:0]  st, st2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_total = 0;
    int done_total = 0;
    int t_send = 0;

    logic [7:0] exp_q[$];

    fpu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rstn(rstn), .result(result), .send(send),
        .tx(tx), .busy(busy), .done(done), .dbg_state(st)
    );

    fpu_result_uart_tx #(.CLKS_PER_BIT(CPB2)) dut2 (
        .clk(clk), .rstn(rstn), .result(result2), .send(send2),
        .tx(tx2), .busy(busy2), .done(done2), .dbg_state(st2)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy === 1'b1) busy_total <= busy_total + 1;
        if (done === 1'b1) done_total <= done_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic txs(input int sel);
        return (sel != 0) ? tx2 : tx;
    endfunction

    function automatic logic dones(input int sel);
        return (sel != 0) ? done2 : done;
    endfunction

    // driver tasks
    task automatic send_word(input int sel, input logic [31:0] w);
        @(negedge clk);
        if (sel != 0) begin
            result2 = w;
            send2 = 1'b1;
        end else begin
            result = w;
            send = 1'b1;
        end
        t_send = cyc;
        @(negedge clk);
        send  = 1'b0;
        send2 = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic recv_byte(input int sel, output logic [7:0] b);
        int n;
        int cp;
        logic [7:0] d;
        n  = 0;
        cp = (sel != 0) ? CPB2 : CPB;
        d  = '0;
        while (txs(sel) !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(n < 5000), 32'd1);
        repeat (cp / 2) @(negedge clk);
        check("start_bit", 32'(txs(sel)), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (cp) @(negedge clk);
            d[k] = txs(sel);
        end
        repeat (cp) @(negedge clk);
        check("stop_bit", 32'(txs(sel)), 32'd1);
        b = d;
    endtask

    // scoreboard: each decoded byte is matched against the head of exp_q
    task automatic recv_word(input int sel);
        logic [7:0] b;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            recv_byte(sel, b);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("rx_byte", 32'(b), 32'(e));
        end
    endtask

    task automatic wait_done(input int sel, output int c);
        int n;
        n = 0;
        while (dones(sel) !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(n < 5000), 32'd1);
        c = cyc;
    endtask

    initial begin
        int c;
        int b0;
        int d0;
        logic [31:0] w;
        logic [7:0] by;
        logic exp_bit;
        int bi;
        int pos;

        rstn = 1'b0;
        send = 1'b0;
        send2 = 1'b0;
        result = '0;
        result2 = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(st), 32'd0);
        check("rst_tx2", 32'(tx2), 32'd1);
        check("rst_state2", 32'(st2), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // nominal frame
        b0 = busy_total;
        d0 = done_total;
        push_word(32'h40ADF06F);
        send_word(0, 32'h40ADF06F);
        check("first_tx", 32'(tx), 32'd0);
        check("first_busy", 32'(busy), 32'd1);
        recv_word(0);
        wait_done(0, c);
        check("done_cycle", 32'(c - t_send), 32'd161);
        check("done_busy", 32'(busy), 32'd0);
        check("done_state", 32'(st), 32'd0);
        check("busy_len", 32'(busy_total - b0), 32'd160);
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("done_count1", 32'(done_total - d0), 32'd1);

        // result changes during the frame
        push_word(32'h3A378000);
        send_word(0, 32'h3A378000);
        fork
            recv_word(0);
            begin
                repeat (4) @(negedge clk);
                result = 32'hFFFFFFFF;
            end
        join
        wait_done(0, c);
        repeat (2) @(negedge clk);

        // send while busy is ignored
        b0 = busy_total;
        d0 = done_total;
        push_word(32'h12345678);
        send_word(0, 32'h12345678);
        fork
            recv_word(0);
            begin
                repeat (48) @(negedge clk);
                result = 32'hDEADBEEF;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        wait_done(0, c);
        repeat (60) @(negedge clk);
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_tx", 32'(tx), 32'd1);
        check("ign_done_count", 32'(done_total - d0), 32'd1);
        check("ign_busy_len", 32'(busy_total - b0), 32'd160);

        // reset in the DATA state of the third byte
        send_word(0, 32'hC0FFEE11);
        repeat (90) @(negedge clk);
        check("pre_rst_state", 32'(st), 32'd2);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(st), 32'd0);
        repeat (5) @(negedge clk);
        check("abort_idle_tx", 32'(tx), 32'd1);
        check("abort_idle_busy", 32'(busy), 32'd0);
        push_word(32'h00000000);
        send_word(0, 32'h00000000);
        recv_word(0);
        wait_done(0, c);
        repeat (2) @(negedge clk);

        // back-to-back with send held high
        d0 = done_total;
        push_word(32'h80000001);
        @(negedge clk);
        result = 32'h80000001;
        send = 1'b1;
        recv_word(0);
        wait_done(0, c);
        check("b2b_gap_tx", 32'(tx), 32'd1);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("b2b_start_tx", 32'(tx), 32'd0);
        check("b2b_start_busy", 32'(busy), 32'd1);
        send = 1'b0;
        push_word(32'h80000001);
        recv_word(0);
        wait_done(0, c);
        repeat (3) @(negedge clk);
        check("b2b_done_count", 32'(done_total - d0), 32'd2);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // fast baud: every line cycle compared against the expected bit pattern
        w = 32'h55555555;
        send_word(1, w);
        for (int k = 0; k < 80; k++) begin
            bi  = k / 20;
            pos = (k % 20) / CPB2;
            by  = w[31 - 8 * bi -: 8];
            if (pos == 0) exp_bit = 1'b0;
            else if (pos == 9) exp_bit = 1'b1;
            else exp_bit = by[pos - 1];
            check("baud2_bit", 32'(tx2), 32'(exp_bit));
            check("baud2_busy", 32'(busy2), 32'd1);
            @(negedge clk);
        end
        check("baud2_done", 32'(done2), 32'd1);
        check("baud2_end_busy", 32'(busy2), 32'd0);
        check("baud2_end_state", 32'(st2), 32'd0);
        @(negedge clk);
        check("baud2_done_end", 32'(done2), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
